// File: rtl/approx_mul_pkg.sv
// Shared types and default widths for the approximate-multiplier datapath
// and its downstream accumulating stages.
package approx_mul_pkg;

  localparam int unsigned PROD_W      = 16;
  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned LEN_W_DEF   = 8;
  localparam int unsigned MAX_LEN_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags when the true sum
// does not fit in W bits.
module sat_add #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
    sum  = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/prod_accum.sv
// Streaming saturating accumulator of 16-bit products; emits one registered
// sum/count/overflow result per vector closed by in_last or by MAX_LEN beats.
module prod_accum
  import approx_mul_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [LEN_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [LEN_W-1:0] count_inc;
  logic             accept;
  logic             closing;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (ACC_W'(in_prod)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Ready is combinational from out_ready so a pop and a refill share one edge.
  assign in_ready  = (state != HOLD) || out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign count_inc = count + LEN_W'(1);
  assign closing   = in_last || (count_inc == LEN_W'(MAX_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN: begin
        if (accept) state_next = closing ? HOLD : RUN;
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) state_next = closing ? HOLD : RUN;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A closing beat moves the running totals into the result registers and
  // clears them, so the next vector always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (closing) begin
        out_sum   <= add_sum;
        out_count <= count_inc;
        out_ovf   <= ovf | add_ovf;
        acc       <= '0;
        count     <= '0;
        ovf       <= 1'b0;
      end else begin
        acc   <= add_sum;
        count <= count_inc;
        ovf   <= ovf | add_ovf;
      end
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a 17-bit instance exercises saturation and a
// default 24-bit instance, driven by the same stimulus, confirms no clamp.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        r17, v17, o17;
  logic [16:0] s17;
  logic [7:0]  c17;
  logic        r24, v24, o24;
  logic [23:0] s24;
  logic [7:0]  c24;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(17), .LEN_W(8), .MAX_LEN(255)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r17),
    .in_prod(in_prod), .in_last(in_last), .out_valid(v17),
    .out_ready(out_ready), .out_sum(s17), .out_count(c17), .out_ovf(o17)
  );

  prod_accum dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r24),
    .in_prod(in_prod), .in_last(in_last), .out_valid(v24),
    .out_ready(out_ready), .out_sum(s24), .out_count(c24), .out_ovf(o24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk17(input string tag, input int v, input int s, input int c, input int o);
    chk({tag, ".valid"}, 32'(v17), 32'(v));
    chk({tag, ".sum"},   32'(s17), 32'(s));
    chk({tag, ".count"}, 32'(c17), 32'(c));
    chk({tag, ".ovf"},   32'(o17), 32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    #2;
    chk17("reset", 0, 0, 0, 0);
    chk("reset.ready", 32'(r17), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // Vector {3,5,7}
    send(16'd3, 1'b0);
    send(16'd5, 1'b0);
    send(16'd7, 1'b1);
    chk17("vec357", 1, 15, 3, 0);
    chk("vec357.sum24", 32'(s24), 32'd15);
    tick();
    chk("vec357.pulse", 32'(v17), 32'd0);

    // Saturation on 17 bits, none on 24 bits
    send(16'd65025, 1'b0);
    send(16'd65025, 1'b0);
    send(16'd65025, 1'b1);
    chk17("sat", 1, 131071, 3, 1);
    chk("sat.sum24", 32'(s24), 32'd195075);
    chk("sat.ovf24", 32'(o24), 32'd0);
    send(16'd1, 1'b1);
    chk17("after_sat", 1, 1, 1, 0);

    // Forced close at MAX_LEN, then remainder closed by in_last
    for (int i = 0; i < 300; i++) begin
      send(16'd1, 1'(i == 299));
      if (i == 254) chk17("forced", 1, 255, 255, 0);
    end
    chk17("remainder", 1, 45, 45, 0);

    // Backpressure: result held, input blocked even with a closing beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 16'd100; in_last = 1'b1;
    #1;
    chk("stall.ready", 32'(r17), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall.valid", 32'(v17), 32'd1);
      chk("stall.sum", 32'(s17), 32'd45);
      chk("stall.ready_hold", 32'(r24), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    send(16'd9, 1'b1);
    chk17("pop_refill", 1, 9, 1, 0);

    // Asynchronous reset mid-vector discards the partial sum
    send(16'd2, 1'b0);
    chk("midvec.valid", 32'(v17), 32'd0);
    send(16'd3, 1'b0);
    rst = 1'b1;
    #1;
    chk17("in_reset", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    send(16'd4, 1'b1);
    chk17("post_reset", 1, 4, 1, 0);

    // Back-to-back single-beat vectors at full rate
    chk("b2b.ready0", 32'(r17), 32'd1);
    send(16'd1, 1'b1);
    chk17("b2b1", 1, 1, 1, 0);
    chk("b2b.ready1", 32'(r17), 32'd1);
    send(16'd2, 1'b1);
    chk17("b2b2", 1, 2, 1, 0);
    chk("b2b.ready2", 32'(r17), 32'd1);
    send(16'd3, 1'b1);
    chk17("b2b3", 1, 3, 1, 0);
    tick();
    chk("b2b.drain", 32'(v17), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
